univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register for the lab datapath: parallel load, single-step shifting in five modes (logical/arithmetic/rotate, both directions), and an autonomous multi-step burst sequencer with a Busy/Done handshake. It succeeds the fixed 8-bit right-shift register and serves as the operand register for the shift-add multiplier and barrel-free shift units. The controller steps it either one bit per Shift_EN or N bits per Start.

## Interface
- N, default 8: register width, N >= 2.
- CNT_W, default $clog2(N)+1: burst-count width, large enough to hold N.
- clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Load  in  1  parallel load of Din; highest priority.
- Din  in  N  parallel load data.
- Mode  in  3  shift mode: 000 logical right, 001 logical left, 010 arithmetic right, 011 rotate right, 100 rotate left, 101-111 hold.
- Shift_EN  in  1  single-step shift request.
- Start  in  1  begin burst of Count shifts.
- Count  in  CNT_W  burst length, sampled with Start.
- Shift_IN_R  in  1  serial bit entering the MSB on logical right shift.
- Shift_IN_L  in  1  serial bit entering the LSB on logical left shift.
- Dout  out  N  register contents.
- Shift_Out  out  1  registered copy of the bit that left the register on the most recent shift.
- Busy  out  1  burst in progress.
- Done  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, Dout=0, Shift_Out=0, Busy=0, Done=0, internal count=0, latched mode=000.
- Priority per edge: Load > Start > Shift_EN (Start and Shift_EN act only when Busy=0).
- Load in any state: Dout<=Din, Shift_Out unchanged, state goes to IDLE. A burst in progress is aborted and Done is not pulsed.
- Shift per mode, where B is the bit leaving the register and Shift_Out<=B:
  - 000: {Shift_IN_R, Dout[N-1:1]}, B=Dout[0].
  - 001: {Dout[N-2:0], Shift_IN_L}, B=Dout[N-1].
  - 010: {Dout[N-1], Dout[N-1:1]}, B=Dout[0].
  - 011: {Dout[0], Dout[N-1:1]}, B=Dout[0].
  - 100: {Dout[N-2:0], Dout[N-1]}, B=Dout[N-1].
  - 101-111: Dout and Shift_Out hold.
- Single step: in IDLE or DONE with Shift_EN=1, Load=0 and Start=0, perform one shift using the current Mode. The state becomes IDLE.
- Burst: in IDLE or DONE with Start=1 and Load=0, latch Mode and Count.
  - Count>0: go to BUSY. One shift per cycle uses the latched mode; Mode input changes are ignored. Each shift decrements the count. After the shift that brings the count to 0, go to DONE.
  - Count=0: go directly to DONE with no shift.
- BUSY ignores Start and Shift_EN.
- DONE lasts one cycle, then goes to IDLE unless a new Start or Shift_EN is accepted in that cycle.
- Count>N is legal; shifting simply continues (rotates wrap fully).

## Timing
- Load and single-step latency: 1 cycle. The result is visible on Dout after the sampling edge.
- Burst with Start sampled at edge 0 and Count=C>0:
  - Busy is high from after edge 0 through edge C.
  - Shifts occur at edges 1..C.
  - Done is high for exactly one cycle, between edges C and C+1, with Busy=0 in that cycle.
  - Total Start-to-Done: C+1 cycles.
- Count=0: Done is high in the cycle after edge 0, with no Dout change.
- Busy and Done are registered, never both high, and Done is never high for more than one consecutive cycle unless bursts are back-to-back.
- Reset_n low asynchronously forces all outputs to their reset values mid-burst. After release, the block is IDLE and no Done is issued.

## Test plan
- Reset mid-burst: load 8'hFF, start a burst with Count=5, assert Reset_n low after 2 shifts -> Dout=0, Busy=0, Done=0 immediately; next Start works normally.
- Arithmetic right burst: Load Din=8'hB4, Mode=010, Count=3 -> after 3 BUSY cycles Dout=8'hF6, Shift_Out=1, Done pulses exactly once 4 cycles after Start.
- Logical right single steps: Din=8'hB4, Mode=000, Shift_IN_R=0, three Shift_EN pulses -> Dout=8'h16, Shift_Out=1. Then Mode=001, Shift_IN_L=1, one pulse -> Dout=8'h2D, Shift_Out=0.
- Rotate left burst of 4 on 8'hB4 -> Dout=8'h4B. Count=8 rotate right on 8'hB4 -> Dout=8'hB4, Busy high 8 cycles.
- Abort and ignore: during a Count=6 burst, assert Start and Shift_EN (ignored, count unaffected), then Load Din=8'h3C at shift 3 -> Dout=8'h3C, Busy=0, no Done pulse.
- Count=0 Start -> Done one cycle later, Dout unchanged. Start asserted during the DONE cycle -> accepted, new burst begins with no IDLE gap.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, five single-step shift modes
// and a burst sequencer that performs Count shifts in a row.
//
// Ports:
//   clk         rising-edge clock
//   Reset_n     asynchronous active-low reset
//   Load        parallel load of Din; highest priority and aborts a burst
//   Din         parallel load data
//   Mode        000 lsr, 001 lsl, 010 asr, 011 ror, 100 rol, 101-111 hold
//   Shift_EN    single-step shift request (honoured when not busy)
//   Start       start a burst of Count shifts (honoured when not busy)
//   Count       burst length, sampled together with Start
//   Shift_IN_R  serial bit entering the MSB on logical right shift
//   Shift_IN_L  serial bit entering the LSB on logical left shift
//   Dout        register contents
//   Shift_Out   bit that left the register on the most recent shift
//   Busy        burst in progress
//   Done        one-cycle pulse when a burst completes
module univ_shift_reg #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [N-1:0]     Din,
    input  logic [2:0]       Mode,
    input  logic             Shift_EN,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic             Shift_IN_R,
    input  logic             Shift_IN_L,
    output logic [N-1:0]     Dout,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             sout_q, sout_d;

    // Shifter: a burst uses the mode latched at Start, a single step the live Mode.
    logic [2:0]   sh_mode;
    logic [N-1:0] sh_val;
    logic         sh_bit;

    always_comb begin
        sh_mode = (state_q == BUSY) ? mode_q : Mode;
        sh_val  = dout_q;
        sh_bit  = sout_q;
        case (sh_mode)
            3'b000: begin
                sh_val = {Shift_IN_R, dout_q[N-1:1]};
                sh_bit = dout_q[0];
            end
            3'b001: begin
                sh_val = {dout_q[N-2:0], Shift_IN_L};
                sh_bit = dout_q[N-1];
            end
            3'b010: begin
                sh_val = {dout_q[N-1], dout_q[N-1:1]};
                sh_bit = dout_q[0];
            end
            3'b011: begin
                sh_val = {dout_q[0], dout_q[N-1:1]};
                sh_bit = dout_q[0];
            end
            3'b100: begin
                sh_val = {dout_q[N-2:0], dout_q[N-1]};
                sh_bit = dout_q[N-1];
            end
            default: begin
                sh_val = dout_q;
                sh_bit = sout_q;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dout_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
        end
    end

    // Next-state and next-datapath logic; priority Load > Start > Shift_EN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        sout_d  = sout_q;
        if (Load) begin
            state_d = IDLE;
            dout_d  = Din;
        end else begin
            case (state_q)
                BUSY: begin
                    dout_d = sh_val;
                    sout_d = sh_bit;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    if (Start) begin
                        mode_d  = Mode;
                        cnt_d   = Count;
                        // A zero-length burst completes without shifting.
                        state_d = (Count == '0) ? DONE : BUSY;
                    end else if (Shift_EN) begin
                        dout_d  = sh_val;
                        sout_d  = sh_bit;
                        state_d = IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    always_comb begin
        Busy      = (state_q == BUSY);
        Done      = (state_q == DONE);
        Dout      = dout_q;
        Shift_Out = sout_q;
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    logic       clk;
    logic       Reset_n;
    logic       Load;
    logic [7:0] Din;
    logic [2:0] Mode;
    logic       Shift_EN;
    logic       Start;
    logic [3:0] Count;
    logic       Shift_IN_R;
    logic       Shift_IN_L;
    logic [7:0] Dout;
    logic       Shift_Out;
    logic       Busy;
    logic       Done;

    int n_vec;
    int n_err;

    univ_shift_reg #(.N(8), .CNT_W(4)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .Load       (Load),
        .Din        (Din),
        .Mode       (Mode),
        .Shift_EN   (Shift_EN),
        .Start      (Start),
        .Count      (Count),
        .Shift_IN_R (Shift_IN_R),
        .Shift_IN_L (Shift_IN_L),
        .Dout       (Dout),
        .Shift_Out  (Shift_Out),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [7:0] din;
        logic [2:0] mode;
        logic       sen;
        logic       start;
        logic [3:0] cnt;
        logic       sir;
        logic       sil;
        logic [7:0] e_dout;
        logic       e_sout;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    function automatic vec_t mk(input logic load, input logic [7:0] din, input logic [2:0] mode,
                                input logic sen, input logic start, input logic [3:0] cnt,
                                input logic sir, input logic sil, input logic [7:0] e_dout,
                                input logic e_sout, input logic e_busy, input logic e_done);
        vec_t v;
        v.load = load; v.din = din; v.mode = mode; v.sen = sen; v.start = start; v.cnt = cnt;
        v.sir = sir; v.sil = sil; v.e_dout = e_dout; v.e_sout = e_sout;
        v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Load = 1'b0; Din = 8'h00; Mode = 3'b000; Shift_EN = 1'b0; Start = 1'b0;
        Count = 4'd0; Shift_IN_R = 1'b0; Shift_IN_L = 1'b0;
    endtask

    task automatic load_val(input logic [7:0] v);
        Load = 1'b1; Din = v;
        step();
        Load = 1'b0;
    endtask

    // Step until Done or bound; edges = edges taken, busy_n = cycles seen busy.
    task automatic run_to_done(input string name, input int bound, output int edges, output int busy_n);
        edges = 0;
        busy_n = 0;
        while (edges < bound) begin
            step();
            edges++;
            if (Busy) busy_n++;
            if (Done) break;
        end
        if (!Done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: Done not seen within %0d cycles", name, bound);
        end
    endtask

    vec_t vt[20];
    int   e, b, pulses;

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        Reset_n = 1'b0;

        vt[0]  = mk(1, 8'hB4, 3'd0, 0, 0, 4'd0, 0, 0, 8'hB4, 0, 0, 0);
        vt[1]  = mk(0, 8'h00, 3'd0, 1, 0, 4'd0, 0, 0, 8'h5A, 0, 0, 0);
        vt[2]  = mk(0, 8'h00, 3'd0, 1, 0, 4'd0, 0, 0, 8'h2D, 0, 0, 0);
        vt[3]  = mk(0, 8'h00, 3'd0, 1, 0, 4'd0, 0, 0, 8'h16, 1, 0, 0);
        vt[4]  = mk(0, 8'h00, 3'd1, 1, 0, 4'd0, 0, 1, 8'h2D, 0, 0, 0);
        vt[5]  = mk(0, 8'h00, 3'd2, 1, 0, 4'd0, 0, 0, 8'h16, 1, 0, 0);
        vt[6]  = mk(1, 8'h81, 3'd0, 0, 0, 4'd0, 0, 0, 8'h81, 1, 0, 0);
        vt[7]  = mk(0, 8'h00, 3'd2, 1, 0, 4'd0, 0, 0, 8'hC0, 1, 0, 0);
        vt[8]  = mk(0, 8'h00, 3'd3, 1, 0, 4'd0, 0, 0, 8'h60, 0, 0, 0);
        vt[9]  = mk(0, 8'h00, 3'd4, 1, 0, 4'd0, 0, 0, 8'hC0, 0, 0, 0);
        vt[10] = mk(0, 8'h00, 3'd4, 1, 0, 4'd0, 0, 0, 8'h81, 1, 0, 0);
        vt[11] = mk(0, 8'h00, 3'd5, 1, 0, 4'd0, 0, 0, 8'h81, 1, 0, 0);
        vt[12] = mk(0, 8'h00, 3'd7, 1, 0, 4'd0, 0, 0, 8'h81, 1, 0, 0);
        vt[13] = mk(0, 8'h00, 3'd0, 1, 0, 4'd0, 1, 0, 8'hC0, 1, 0, 0);
        vt[14] = mk(0, 8'h00, 3'd0, 0, 0, 4'd0, 0, 0, 8'hC0, 1, 0, 0);
        vt[15] = mk(0, 8'h00, 3'd1, 1, 0, 4'd0, 0, 0, 8'h80, 1, 0, 0);
        vt[16] = mk(1, 8'h5A, 3'd0, 1, 0, 4'd0, 0, 0, 8'h5A, 1, 0, 0);
        vt[17] = mk(1, 8'h3C, 3'd0, 0, 1, 4'd3, 0, 0, 8'h3C, 1, 0, 0);
        vt[18] = mk(0, 8'h00, 3'd0, 0, 1, 4'd0, 0, 0, 8'h3C, 1, 0, 1);
        vt[19] = mk(0, 8'h00, 3'd0, 0, 0, 4'd0, 0, 0, 8'h3C, 1, 0, 0);

        // Reset values while reset is held
        #3;
        chk("reset dout", 32'(Dout), 32'h00);
        chk("reset sout", 32'(Shift_Out), 32'h0);
        chk("reset busy", 32'(Busy), 32'h0);
        chk("reset done", 32'(Done), 32'h0);
        #9;
        Reset_n = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 20; i++) begin
            Load = vt[i].load; Din = vt[i].din; Mode = vt[i].mode; Shift_EN = vt[i].sen;
            Start = vt[i].start; Count = vt[i].cnt; Shift_IN_R = vt[i].sir; Shift_IN_L = vt[i].sil;
            step();
            chk($sformatf("vec%0d dout", i), 32'(Dout), 32'(vt[i].e_dout));
            chk($sformatf("vec%0d sout", i), 32'(Shift_Out), 32'(vt[i].e_sout));
            chk($sformatf("vec%0d busy", i), 32'(Busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(Done), 32'(vt[i].e_done));
        end
        idle_inputs();

        // Arithmetic right burst of 3 on B4, Mode changed mid-burst
        load_val(8'hB4);
        Mode = 3'd2; Start = 1'b1; Count = 4'd3;
        step();
        Start = 1'b0; Mode = 3'd1;
        chk("asr start busy", 32'(Busy), 32'h1);
        chk("asr start done", 32'(Done), 32'h0);
        chk("asr start dout", 32'(Dout), 32'hB4);
        run_to_done("asr", 10, e, b);
        chk("asr done edge", 32'(e), 32'd3);
        chk("asr busy cycles", 32'(b), 32'd2);
        chk("asr dout", 32'(Dout), 32'hF6);
        chk("asr sout", 32'(Shift_Out), 32'h1);
        chk("asr busy at done", 32'(Busy), 32'h0);
        step();
        chk("asr done single", 32'(Done), 32'h0);

        // Rotate left burst of 4
        idle_inputs();
        load_val(8'hB4);
        Mode = 3'd4; Start = 1'b1; Count = 4'd4;
        step();
        Start = 1'b0;
        run_to_done("rol4", 10, e, b);
        chk("rol4 done edge", 32'(e), 32'd4);
        chk("rol4 dout", 32'(Dout), 32'h4B);

        // Rotate right full wrap, Count = N
        idle_inputs();
        load_val(8'hB4);
        Mode = 3'd3; Start = 1'b1; Count = 4'd8;
        step();
        Start = 1'b0;
        chk("ror8 start busy", 32'(Busy), 32'h1);
        run_to_done("ror8", 16, e, b);
        chk("ror8 done edge", 32'(e), 32'd8);
        chk("ror8 busy cycles", 32'(b + 1), 32'd8);
        chk("ror8 dout", 32'(Dout), 32'hB4);
        chk("ror8 sout", 32'(Shift_Out), 32'h1);

        // Ignore Start/Shift_EN while busy, then abort with Load
        idle_inputs();
        load_val(8'hB4);
        Mode = 3'd3; Start = 1'b1; Count = 4'd6;
        step();
        Start = 1'b1; Count = 4'd2; Mode = 3'd1; Shift_EN = 1'b1;
        step();
        chk("abort s1 dout", 32'(Dout), 32'h5A);
        Start = 1'b0; Shift_EN = 1'b0;
        step();
        chk("abort s2 dout", 32'(Dout), 32'h2D);
        chk("abort s2 busy", 32'(Busy), 32'h1);
        chk("abort s2 done", 32'(Done), 32'h0);
        load_val(8'h3C);
        chk("abort dout", 32'(Dout), 32'h3C);
        chk("abort busy", 32'(Busy), 32'h0);
        chk("abort done", 32'(Done), 32'h0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (Done) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'd0);

        // Count = 0, then Start accepted in the DONE cycle
        idle_inputs();
        load_val(8'h3C);
        Mode = 3'd0; Start = 1'b1; Count = 4'd0;
        step();
        chk("cnt0 done", 32'(Done), 32'h1);
        chk("cnt0 busy", 32'(Busy), 32'h0);
        chk("cnt0 dout", 32'(Dout), 32'h3C);
        Mode = 3'd1; Start = 1'b1; Count = 4'd2; Shift_IN_L = 1'b0;
        step();
        Start = 1'b0;
        chk("b2b busy", 32'(Busy), 32'h1);
        chk("b2b done", 32'(Done), 32'h0);
        run_to_done("b2b", 10, e, b);
        chk("b2b done edge", 32'(e), 32'd2);
        chk("b2b dout", 32'(Dout), 32'hF0);
        chk("b2b sout", 32'(Shift_Out), 32'h0);

        // Asynchronous reset in the middle of a burst
        idle_inputs();
        load_val(8'hFF);
        Mode = 3'd0; Start = 1'b1; Count = 4'd5;
        step();
        Start = 1'b0;
        step();
        step();
        chk("rst pre dout", 32'(Dout), 32'h3F);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst dout", 32'(Dout), 32'h00);
        chk("rst sout", 32'(Shift_Out), 32'h0);
        chk("rst busy", 32'(Busy), 32'h0);
        chk("rst done", 32'(Done), 32'h0);
        #2;
        Reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (Done || Busy) pulses++;
        end
        chk("post rst quiet", 32'(pulses), 32'd0);
        load_val(8'hB4);
        Mode = 3'd0; Start = 1'b1; Count = 4'd1;
        step();
        Start = 1'b0;
        run_to_done("post rst", 6, e, b);
        chk("post rst edge", 32'(e), 32'd1);
        chk("post rst dout", 32'(Dout), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
